dht11_frame_pkt: RTL and testbench

DHT11_FRAME_PKT -- requirements
Module: dht11_frame_pkt

---
 rtl/dht11_frame_pkt.sv | 157 +++++++++++++++
 tb/tb_dht11_frame_pkt.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_frame_pkt.sv
`default_nettype none
// ============================================================================
// Module : dht11_frame_pkt
// Checksums a 40-bit DHT11 frame and streams it as a 7-byte packet over a
// valid/ready byte interface. Define DHT11_ERR_CNT_EN to add the err_cnt port.
// Rev    : 1.0
// ============================================================================
module dht11_frame_pkt (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic [39:0] frame_in,
  input  logic        frame_vld,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [7:0]  hum_int,
  output logic [7:0]  tmp_int,
  output logic        data_ok,
  output logic        crc_err,
  output logic        drop
`ifdef DHT11_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] frame_q, frame_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hum_q, hum_d;
  logic [7:0]  tmp_q, tmp_d;
  logic        ok_q, ok_d;
  logic        crc_err_q, crc_err_d;
  logic        drop_q, drop_d;
  logic [7:0]  sum;

  assign sum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      hum_q     <= '0;
      tmp_q     <= '0;
      ok_q      <= 1'b0;
      crc_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      hum_q     <= hum_d;
      tmp_q     <= tmp_d;
      ok_q      <= ok_d;
      crc_err_q <= crc_err_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    hum_d     = hum_q;
    tmp_d     = tmp_q;
    ok_d      = ok_q;
    crc_err_d = 1'b0;
    drop_d    = frame_vld && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_vld) begin
          frame_d = frame_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (sum == frame_q[7:0]) begin
          hum_d   = frame_q[39:32];
          tmp_d   = frame_q[23:16];
          ok_d    = 1'b1;
          idx_d   = 3'd0;
          state_d = SEND;
        end else begin
          crc_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      SEND: begin
        if (tx_rdy) begin
          if (idx_q == 3'd6) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The captured frame is frozen while busy, so it doubles as the packet store.
  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    tx_data = 8'hAA;
        3'd1:    tx_data = 8'h55;
        3'd2:    tx_data = frame_q[39:32];
        3'd3:    tx_data = frame_q[31:24];
        3'd4:    tx_data = frame_q[23:16];
        3'd5:    tx_data = frame_q[15:8];
        3'd6:    tx_data = frame_q[7:0];
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign tx_vld  = (state_q == SEND);
  assign hum_int = hum_q;
  assign tmp_int = tmp_q;
  assign data_ok = ok_q;
  assign crc_err = crc_err_q;
  assign drop    = drop_q;

`ifdef DHT11_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A simultaneous checksum error and drop count as one event.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((crc_err_d || drop_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dht11_frame_pkt.sv
`default_nettype none
// ============================================================================
// Module : tb_dht11_frame_pkt
// Vector table plus directed sequences; expected tx bytes flow through a queue.
// Rev    : 1.0
// ============================================================================
module tb_dht11_frame_pkt;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic [39:0] frame_in;
  logic        frame_vld;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic [7:0]  hum_int;
  logic [7:0]  tmp_int;
  logic        data_ok;
  logic        crc_err;
  logic        drop;
`ifdef DHT11_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #10 clk_50m = ~clk_50m;

  dht11_frame_pkt dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .frame_in  (frame_in),
    .frame_vld (frame_vld),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_vld    (tx_vld),
    .tx_rdy    (tx_rdy),
    .hum_int   (hum_int),
    .tmp_int   (tmp_int),
    .data_ok   (data_ok),
    .crc_err   (crc_err),
    .drop      (drop)
`ifdef DHT11_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [39:0] frame;
    logic        good;
    logic [7:0]  exp_hum;
    logic [7:0]  exp_tmp;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: the byte handshake is scored at the falling edge, then we land
  // 1 ns after the next rising edge where new stimulus is driven.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk_50m);
    if (rst_n && tx_vld && tx_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_byte", {56'd0, tx_data}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {56'd0, tx_data}, {56'd0, e});
      end
    end
    @(posedge clk_50m);
    #1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    frame_in  = f;
    frame_vld = 1'b1;
    tick();
    frame_vld = 1'b0;
  endtask

  task automatic push_pkt(input logic [39:0] f);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int k = 4; k >= 0; k--) exp_q.push_back(f[k*8 +: 8]);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 50) begin
      tick();
      cyc++;
    end
    if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  initial begin
    int cyc;

    vecs[0] = '{40'h3C001A0056, 1'b1, 8'h3C, 8'h1A};
    vecs[1] = '{40'h3C001A0057, 1'b0, 8'h3C, 8'h1A};
    vecs[2] = '{40'hFF01FF0100, 1'b1, 8'hFF, 8'hFF};
    vecs[3] = '{40'h0000000000, 1'b1, 8'h00, 8'h00};
    vecs[4] = '{40'h10203040A1, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{40'h10203040A0, 1'b1, 8'h10, 8'h30};
    vecs[6] = '{40'h3205190252, 1'b1, 8'h32, 8'h19};

    rst_n     = 1'b0;
    frame_in  = '0;
    frame_vld = 1'b0;
    tx_rdy    = 1'b1;
    #1;
    chk("reset_outputs", {busy, tx_vld, tx_data, hum_int, tmp_int, data_ok, crc_err, drop}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
`ifdef DHT11_ERR_CNT_EN
    chk("reset_err_cnt", {56'd0, err_cnt}, 64'd0);
`endif

    // Table vectors, tx_rdy always high
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].good) push_pkt(vecs[i].frame);
      else bump_err();
      send_frame(vecs[i].frame);
      tick();
      chk("crc_err_at_n2", {63'd0, crc_err}, {63'd0, !vecs[i].good});
      chk("tx_vld_at_n2", {63'd0, tx_vld}, {63'd0, vecs[i].good});
      chk("hum_int", {56'd0, hum_int}, {56'd0, vecs[i].exp_hum});
      chk("tmp_int", {56'd0, tmp_int}, {56'd0, vecs[i].exp_tmp});
      chk("data_ok", {63'd0, data_ok}, 64'd1);
`ifdef DHT11_ERR_CNT_EN
      chk("err_cnt", {56'd0, err_cnt}, exp_err);
`endif
      wait_idle(cyc);
      chk("send_cycles", cyc, vecs[i].good ? 64'd7 : 64'd0);
      tick();
      chk("crc_err_cleared", {63'd0, crc_err}, 64'd0);
      chk("tx_vld_idle", {63'd0, tx_vld}, 64'd0);
    end

    // Back-pressure on byte 2
    tx_rdy = 1'b0;
    push_pkt(40'h3C001A0056);
    send_frame(40'h3C001A0056);
    tick();
    tx_rdy = 1'b1;
    tick();
    tick();
    tx_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("stall_hold", {55'd0, tx_vld, tx_data}, {55'd0, 1'b1, 8'h3C});
      tick();
    end
    tx_rdy = 1'b1;
    wait_idle(cyc);

    // Frame arriving while busy is dropped
    push_pkt(40'h3205190252);
    send_frame(40'h3205190252);
    tick();
    tick();
    frame_in  = 40'h10203040A0;
    frame_vld = 1'b1;
    tick();
    frame_vld = 1'b0;
    bump_err();
    chk("drop_pulse", {63'd0, drop}, 64'd1);
    tick();
    chk("drop_single", {63'd0, drop}, 64'd0);
`ifdef DHT11_ERR_CNT_EN
    chk("err_cnt_drop", {56'd0, err_cnt}, exp_err);
`endif
    wait_idle(cyc);
    chk("hum_after_drop", {56'd0, hum_int}, 64'h32);

    // Reset while byte 4 is offered
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00);
    send_frame(40'h3C001A0056);
    tick();
    repeat (4) tick();
    chk("byte4_offered", {56'd0, tx_data}, 64'h1A);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, tx_vld, tx_data, hum_int, tmp_int, data_ok, crc_err, drop}, 64'd0);
`ifdef DHT11_ERR_CNT_EN
    chk("async_reset_err_cnt", {56'd0, err_cnt}, 64'd0);
`endif
    exp_err = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("no_tx_after_reset", {63'd0, tx_vld}, 64'd0);
    end

    // Wrapping checksum accepted straight after a reset
    push_pkt(40'hFF01FF0100);
    send_frame(40'hFF01FF0100);
    tick();
    chk("wrap_hum", {56'd0, hum_int}, 64'hFF);
    wait_idle(cyc);
    chk("wrap_cycles", cyc, 64'd7);

`ifdef DHT11_ERR_CNT_EN
    for (int k = 0; k < 260; k++) begin
      send_frame(40'h0000000001);
      tick();
      tick();
      bump_err();
    end
    chk("err_cnt_saturate", {56'd0, err_cnt}, exp_err);
    chk("err_cnt_ff", {56'd0, err_cnt}, 64'hFF);
`endif

    chk("queue_drained", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
